aes_selftest_checker: RTL and testbench
=======================================

# aes_selftest_checker

Power-on self-test monitor for the AES encrypt/decrypt loopback top level. It captures the ciphertext from the encryption-side master and the recovered plaintext from the decryption-side master. It compares both against FIPS-197 known-answer values and drives the three board LEDs with pass, fail and busy status. A watchdog counter flags a hung SPI chain.

## Interface

Parameters:
- EXP_CT, 128'h69c4e0d86a7b0430d8cdb78070b4c55a: expected ciphertext (AES-128 of the test vector).
- EXP_PT, 128'h00112233445566778899aabbccddeeff: expected recovered plaintext.
- TIMEOUT_CYCLES, 65536: maximum cycles allowed in each wait state.
- BLINK_DIV, 24: width of the free-running LED blink counter; blink rate is clk / 2^BLINK_DIV.

Ports:
- clk, in, 1: system clock; all logic is on the rising edge.
- rst, in, 1: reset, synchronous and active-high.
- start, in, 1: begins a test run when sampled high in IDLE, PASS or FAIL.
- enc_valid, in, 1: ciphertext strobe from the encryption master; one or more cycles high.
- enc_data, in, 128: ciphertext word; sampled only when enc_valid is high.
- dec_valid, in, 1: recovered-plaintext strobe from the decryption master.
- dec_data, in, 128: recovered plaintext; sampled only when dec_valid is high.
- done, out, 1: test finished (PASS or FAIL state).
- pass, out, 1: test finished and both compares matched.
- err_code, out, 2: 0 = none, 1 = ciphertext mismatch, 2 = plaintext mismatch, 3 = timeout.
- led1, out, 1: steady on in PASS.
- led2, out, 1: steady on in FAIL with a mismatch; blinks in FAIL with a timeout.
- led3, out, 1: heartbeat blink while in WAIT_ENC or WAIT_DEC.

## Operation

- FSM states: IDLE, WAIT_ENC, WAIT_DEC, PASS, FAIL.
- IDLE:
  - start goes to WAIT_ENC.
  - Timeout counter, captured registers, ct_ok, err_code and done are cleared.
- WAIT_ENC:
  - enc_valid captures enc_data into ct_reg.
  - ct_ok is set to (enc_data == EXP_CT).
  - Timeout counter clears; FSM goes to WAIT_DEC.
  - dec_valid is ignored in this state, including when it is high together with enc_valid.
- WAIT_DEC:
  - dec_valid captures dec_data.
  - FSM goes to PASS if ct_ok and dec_data == EXP_PT, else to FAIL.
  - On FAIL, err_code = 1 if !ct_ok, else 2. A ciphertext error takes priority over a plaintext error.
  - enc_valid is ignored in this state; the first capture is kept.
- Timeout:
  - The counter increments every cycle in WAIT_ENC and WAIT_DEC.
  - When it equals TIMEOUT_CYCLES-1 and the relevant valid is low, the FSM goes to FAIL with err_code = 3.
  - When the valid and the terminal count fall in the same cycle, the valid wins.
- PASS and FAIL:
  - Held until start or rst.
  - start restarts directly into WAIT_ENC with a fresh clear; the FSM does not pass through IDLE.
- start is ignored while in WAIT_ENC or WAIT_DEC.
- Blink counter:
  - BLINK_DIV bits wide; free-running, wraps to 0; cleared only by rst.
  - blink = counter MSB.
- LED mapping:
  - led1 = (state == PASS).
  - led2 = (state == FAIL) & (err_code == 3 ? blink : 1).
  - led3 = (state is WAIT_ENC or WAIT_DEC) & blink.
- Compares use the full 128-bit width. Byte order is identical to the master's SIPO register: the MSB byte is the first AES state byte.

## Timing

- All outputs are registered or decoded directly from registered state; no combinational path from any input to any output.
- Reset:
  - rst sampled high forces state = IDLE and clears both counters, ct_reg, ct_ok and err_code.
  - done, pass, err_code, led1, led2 and led3 are all 0 in the cycle after the reset edge.
  - rst mid-test aborts the test; no stale result remains visible.
- Latency:
  - start sampled at edge N puts the FSM in WAIT_ENC from cycle N+1.
  - enc_valid sampled at edge M puts the FSM in WAIT_DEC from M+1.
  - dec_valid sampled at edge K makes done, pass and err_code valid from K+1.
- Timeout fires at exactly TIMEOUT_CYCLES cycles after entering a wait state with no valid; done rises the following cycle.
- A multi-cycle valid pulse is consumed once. WAIT_DEC ignores enc_valid, so a long enc_valid never double-captures.

## Test plan

- Known answer:
  - Stimulus: start, then enc_valid with 69c4e0d8…c55a, then 5 cycles later dec_valid with 00112233…eeff.
  - Required: done = 1, pass = 1, err_code = 0, led1 = 1, led2 = 0, all one cycle after dec_valid.
- Ciphertext mismatch:
  - Stimulus: enc_data with bit 0 flipped, correct dec_data.
  - Required: pass = 0, err_code = 1, led2 steady 1.
- Plaintext mismatch:
  - Stimulus: correct enc_data, dec_data = 0.
  - Required: err_code = 2, led2 steady 1, led1 = 0.
- Timeout (TIMEOUT_CYCLES = 16, BLINK_DIV = 4):
  - Stimulus: start with no enc_valid.
  - Required: FAIL entered exactly 16 cycles after WAIT_ENC entry, err_code = 3, led2 toggles every 8 cycles.
  - Repeat with enc_valid on cycle 15: required no timeout.
- Ordering and restart:
  - Stimulus: dec_valid before enc_valid, then enc_valid together with dec_valid, then a separate dec_valid.
  - Required: the first two dec_valid pulses are ignored and the result comes from the third pulse.
  - Stimulus: start while in PASS. Required: a new run starts with err_code cleared.
- Reset mid-run:
  - Stimulus: rst during WAIT_DEC.
  - Required: the next cycle shows state IDLE and all outputs 0; a later start completes a normal PASS.

Source files
------------

// File: rtl/aes_selftest_checker.sv
// AES loopback power-on self-test monitor.
// Captures the encryption-side ciphertext and the decryption-side recovered
// plaintext, compares both with known-answer values, and drives pass / fail /
// busy LEDs. A per-wait-state watchdog flags a hung SPI chain.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | after reset; everything cleared, waiting for start
// WAIT_ENC | run active, waiting for the ciphertext strobe
// WAIT_DEC | ciphertext compared, waiting for the recovered plaintext
// PASS     | both compares matched; held until start or rst
// FAIL     | mismatch or timeout, reason in err_code; held until start/rst
module aes_selftest_checker #(
    parameter logic [127:0] EXP_CT         = 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
    parameter logic [127:0] EXP_PT         = 128'h00112233445566778899aabbccddeeff,
    parameter int unsigned  TIMEOUT_CYCLES = 65536,
    parameter int unsigned  BLINK_DIV      = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         enc_valid,
    input  logic [127:0] enc_data,
    input  logic         dec_valid,
    input  logic [127:0] dec_data,
    output logic         done,
    output logic         pass,
    output logic [1:0]   err_code,
    output logic         led1,
    output logic         led2,
    output logic         led3
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_CT   = 2'd1;
    localparam logic [1:0] ERR_PT   = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ENC,
        WAIT_DEC,
        PASS,
        FAIL
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     tmo_cnt, tmo_cnt_nxt;
    logic                 ct_ok, ct_ok_nxt;
    logic [1:0]           err_q, err_nxt;
    logic [BLINK_DIV-1:0] blink_cnt;
    logic                 blink;
    logic                 tmo_hit;

    // Only the ciphertext compare result is needed later, so the ciphertext
    // word itself is reduced to ct_ok at capture time rather than stored.
    assign tmo_hit = (tmo_cnt == TMO_LAST);
    assign blink   = blink_cnt[BLINK_DIV-1];

    // Next-state, watchdog and result logic.
    always_comb begin
        state_nxt   = state;
        tmo_cnt_nxt = tmo_cnt;
        ct_ok_nxt   = ct_ok;
        err_nxt     = err_q;
        case (state)
            IDLE: begin
                tmo_cnt_nxt = '0;
                ct_ok_nxt   = 1'b0;
                err_nxt     = ERR_NONE;
                if (start) begin
                    state_nxt = WAIT_ENC;
                end
            end
            WAIT_ENC: begin
                // A valid on the terminal-count cycle still counts as in time.
                if (enc_valid) begin
                    ct_ok_nxt   = (enc_data == EXP_CT);
                    tmo_cnt_nxt = '0;
                    state_nxt   = WAIT_DEC;
                end else if (tmo_hit) begin
                    err_nxt   = ERR_TMO;
                    state_nxt = FAIL;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + CNT_W'(1);
                end
            end
            WAIT_DEC: begin
                if (dec_valid) begin
                    if (ct_ok && (dec_data == EXP_PT)) begin
                        state_nxt = PASS;
                    end else begin
                        err_nxt   = ct_ok ? ERR_PT : ERR_CT;
                        state_nxt = FAIL;
                    end
                end else if (tmo_hit) begin
                    err_nxt   = ERR_TMO;
                    state_nxt = FAIL;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + CNT_W'(1);
                end
            end
            PASS, FAIL: begin
                // Restart goes straight into a fresh run, skipping IDLE.
                if (start) begin
                    tmo_cnt_nxt = '0;
                    ct_ok_nxt   = 1'b0;
                    err_nxt     = ERR_NONE;
                    state_nxt   = WAIT_ENC;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, watchdog and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tmo_cnt <= '0;
            ct_ok   <= 1'b0;
            err_q   <= ERR_NONE;
        end else begin
            state   <= state_nxt;
            tmo_cnt <= tmo_cnt_nxt;
            ct_ok   <= ct_ok_nxt;
            err_q   <= err_nxt;
        end
    end

    // Free-running LED blink divider.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_cnt + BLINK_DIV'(1);
        end
    end

    assign done     = (state == PASS) || (state == FAIL);
    assign pass     = (state == PASS);
    assign err_code = err_q;
    assign led1     = (state == PASS);
    assign led2     = (state == FAIL) && ((err_q == ERR_TMO) ? blink : 1'b1);
    assign led3     = ((state == WAIT_ENC) || (state == WAIT_DEC)) && blink;

endmodule

// File: tb/tb_aes_selftest_checker.sv
// Self-checking bench for aes_selftest_checker with a short watchdog and
// fast blink so timeouts and LED blinking are observable in a few cycles.
module tb_aes_selftest_checker;

    localparam logic [127:0] EXP_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] EXP_PT = 128'h00112233445566778899aabbccddeeff;
    localparam int TMO = 16;
    localparam int BD  = 4;
    localparam int BLK_PERIOD = 1 << BD;

    localparam int PH_IDLE = 0;
    localparam int PH_WAIT = 1;
    localparam int PH_PASS = 2;
    localparam int PH_FAIL = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         enc_valid = 1'b0;
    logic [127:0] enc_data = '0;
    logic         dec_valid = 1'b0;
    logic [127:0] dec_data = '0;
    logic         done, pass, led1, led2, led3;
    logic [1:0]   err_code;

    int errors = 0;
    int checks = 0;
    int since  = 0;     // clock edges since the last edge that saw rst high
    int m_phase = PH_IDLE;
    int m_err   = 0;

    aes_selftest_checker #(
        .EXP_CT        (EXP_CT),
        .EXP_PT        (EXP_PT),
        .TIMEOUT_CYCLES(TMO),
        .BLINK_DIV     (BD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .enc_valid(enc_valid),
        .enc_data (enc_data),
        .dec_valid(dec_valid),
        .dec_data (dec_data),
        .done     (done),
        .pass     (pass),
        .err_code (err_code),
        .led1     (led1),
        .led2     (led2),
        .led3     (led3)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        if (rst) since = 0;
        else since++;
        #1;
    endtask

    function automatic int result_err(input logic [127:0] ct, input logic [127:0] pt);
        if (ct != EXP_CT) return 1;
        if (pt != EXP_PT) return 2;
        return 0;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] pick_word(input logic [127:0] good);
        logic [127:0] one;
        int sel;
        one = 128'd1;
        sel = $urandom_range(0, 4);
        if (sel <= 2) return good;
        if (sel == 3) return good ^ (one << $urandom_range(0, 127));
        return rand128();
    endfunction

    // Expected outputs from the model phase, error and elapsed cycle count.
    task automatic check_outs(input string tag);
        logic       blink_e;
        logic [6:0] exp_v;
        logic [6:0] obs_v;
        blink_e = ((since % BLK_PERIOD) >= (BLK_PERIOD / 2));
        exp_v[6]   = (m_phase == PH_PASS) || (m_phase == PH_FAIL);
        exp_v[5]   = (m_phase == PH_PASS);
        exp_v[4:3] = 2'(m_err);
        exp_v[2]   = (m_phase == PH_PASS);
        exp_v[1]   = (m_phase == PH_FAIL) && ((m_err == 3) ? blink_e : 1'b1);
        exp_v[0]   = (m_phase == PH_WAIT) && blink_e;
        obs_v = {done, pass, err_code, led1, led2, led3};
        checks++;
        assert (obs_v === exp_v) else begin
            errors++;
            $error("FAIL %s: {done,pass,err,led1,led2,led3} observed=%b expected=%b", tag, obs_v, exp_v);
        end
    endtask

    // One complete run: start, ciphertext, plaintext, with chosen gaps/lengths.
    task automatic run(input logic [127:0] ct, input logic [127:0] pt,
                       input int gap_enc, input int enc_len,
                       input int gap_dec, input int dec_len, input string tag);
        int e;
        start = 1'b1;
        step();
        start = 1'b0;
        m_phase = PH_WAIT;
        m_err   = 0;
        check_outs({tag, "_start"});
        for (int i = 0; i < gap_enc; i++) begin
            start = 1'($urandom_range(0, 1));
            step();
            check_outs({tag, "_wait_enc"});
        end
        start = 1'b0;
        enc_valid = 1'b1;
        enc_data  = ct;
        step();
        check_outs({tag, "_enc"});
        for (int i = 1; i < enc_len; i++) begin
            enc_data = rand128();
            step();
            check_outs({tag, "_enc_hold"});
        end
        enc_valid = 1'b0;
        for (int i = 0; i < gap_dec; i++) begin
            step();
            check_outs({tag, "_wait_dec"});
        end
        dec_valid = 1'b1;
        dec_data  = pt;
        step();
        e = result_err(ct, pt);
        m_phase = (e == 0) ? PH_PASS : PH_FAIL;
        m_err   = e;
        check_outs({tag, "_result"});
        for (int i = 1; i < dec_len; i++) begin
            dec_data = rand128();
            step();
            check_outs({tag, "_result_hold"});
        end
        dec_valid = 1'b0;
        step();
        check_outs({tag, "_held"});
    endtask

    initial begin
        logic [127:0] one;
        one = 128'd1;

        // Reset behaviour.
        step();
        check_outs("reset_edge1");
        step();
        check_outs("reset_edge2");
        rst = 1'b0;
        repeat (3) begin
            step();
            check_outs("idle");
        end

        // Known answer, multi-cycle enc_valid.
        run(EXP_CT, EXP_PT, 2, 3, 5, 1, "kat");
        // Ciphertext mismatch (restart from PASS), then plaintext mismatch.
        run(EXP_CT ^ one, EXP_PT, 1, 1, 3, 2, "ct_bad");
        run(EXP_CT, 128'd0, 0, 1, 0, 1, "pt_bad");
        run(EXP_CT ^ one, 128'd0, 3, 2, 1, 1, "both_bad");

        // Randomized runs.
        for (int r = 0; r < 12; r++) begin
            run(pick_word(EXP_CT), pick_word(EXP_PT),
                $urandom_range(0, 10), $urandom_range(1, 3),
                $urandom_range(0, 10), $urandom_range(1, 2), "rand");
        end

        // Timeout in WAIT_ENC: FAIL exactly TMO cycles after entry, led2 blinks.
        start = 1'b1;
        step();
        start = 1'b0;
        m_phase = PH_WAIT;
        m_err   = 0;
        check_outs("tmo_enc_start");
        for (int i = 1; i < TMO; i++) begin
            step();
            check_outs("tmo_enc_wait");
        end
        step();
        m_phase = PH_FAIL;
        m_err   = 3;
        check_outs("tmo_enc_fire");
        for (int i = 0; i < 20; i++) begin
            step();
            check_outs("tmo_blink");
        end

        // Timeout in WAIT_DEC.
        start = 1'b1;
        step();
        start = 1'b0;
        m_phase = PH_WAIT;
        m_err   = 0;
        enc_valid = 1'b1;
        enc_data  = EXP_CT;
        step();
        enc_valid = 1'b0;
        check_outs("tmo_dec_enc");
        for (int i = 1; i < TMO; i++) begin
            step();
            check_outs("tmo_dec_wait");
        end
        step();
        m_phase = PH_FAIL;
        m_err   = 3;
        check_outs("tmo_dec_fire");

        // Valids on the terminal-count cycle win over the timeout.
        start = 1'b1;
        step();
        start = 1'b0;
        m_phase = PH_WAIT;
        m_err   = 0;
        for (int i = 1; i < TMO; i++) begin
            step();
            check_outs("edge_enc_wait");
        end
        enc_valid = 1'b1;
        enc_data  = EXP_CT;
        step();
        enc_valid = 1'b0;
        check_outs("edge_enc_capture");
        for (int i = 1; i < TMO; i++) begin
            step();
            check_outs("edge_dec_wait");
        end
        dec_valid = 1'b1;
        dec_data  = EXP_PT;
        step();
        dec_valid = 1'b0;
        m_phase = PH_PASS;
        check_outs("edge_dec_pass");

        // Ordering: dec before enc and together with enc are ignored.
        start = 1'b1;
        step();
        start = 1'b0;
        m_phase = PH_WAIT;
        m_err   = 0;
        check_outs("order_start");
        dec_valid = 1'b1;
        dec_data  = EXP_PT;
        step();
        dec_valid = 1'b0;
        check_outs("order_early_dec");
        step();
        enc_valid = 1'b1;
        enc_data  = EXP_CT;
        dec_valid = 1'b1;
        dec_data  = 128'd0;
        step();
        enc_valid = 1'b0;
        dec_valid = 1'b0;
        check_outs("order_same_cycle");
        step();
        check_outs("order_gap");
        dec_valid = 1'b1;
        dec_data  = EXP_PT;
        step();
        dec_valid = 1'b0;
        m_phase = PH_PASS;
        check_outs("order_third_dec");

        // Reset during WAIT_DEC aborts; a later run passes normally.
        run(EXP_CT, 128'd0, 0, 1, 0, 1, "pre_abort");
        start = 1'b1;
        step();
        start = 1'b0;
        m_phase = PH_WAIT;
        m_err   = 0;
        enc_valid = 1'b1;
        enc_data  = EXP_CT ^ one;
        step();
        enc_valid = 1'b0;
        check_outs("abort_wait_dec");
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_phase = PH_IDLE;
        m_err   = 0;
        check_outs("abort_reset");
        step();
        check_outs("abort_idle");
        run(EXP_CT, EXP_PT, 1, 1, 2, 1, "after_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
